// File: rtl/change_dispenser_ctrl.sv
// Change dispenser: pays back a credit amount one coin at a time, largest denomination first,
// confirming each coin with its hopper's coin-pass sensor and reporting done or fault.
module change_dispenser_ctrl #(
    parameter int CREDIT_W       = 9,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [CREDIT_W-1:0] amount_i,
    input  logic [3:0]          hopper_empty_i,
    input  logic [3:0]          hopper_sense_i,
    input  logic                fault_clr_i,
    output logic [3:0]          hopper_eject_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [1:0]          err_code_o,
    output logic [CREDIT_W-1:0] remaining_o,
    output logic [7:0]          coin_count_o,
    output logic [2:0]          dbg_state_o
);
    // Handshake: start_i is a single-cycle request accepted only in IDLE; amount_i is
    // sampled on that same edge. done_o is a one-cycle completion pulse, error_o is a level.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EJECT  = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state_q;
    logic [CREDIT_W-1:0] remaining_q;
    logic [7:0]          coin_count_q;
    logic [3:0]          eject_q;
    logic [1:0]          sel_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sensed_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic [1:0]          err_code_q;

    logic                pick_ok;
    logic [1:0]          pick_code;
    logic                sense_hit;
    logic [CREDIT_W-1:0] remaining_d;
    logic [7:0]          coin_count_d;

    function automatic logic [CREDIT_W-1:0] denom_of(input logic [1:0] code);
        case (code)
            2'd0:    denom_of = CREDIT_W'(10);
            2'd1:    denom_of = CREDIT_W'(20);
            2'd3:    denom_of = CREDIT_W'(50);
            default: denom_of = CREDIT_W'(100);
        endcase
    endfunction

    // Checked smallest to largest so the last match (the largest usable coin) wins.
    always_comb begin
        pick_ok   = 1'b0;
        pick_code = 2'd0;
        if (!hopper_empty_i[0] && remaining_q >= denom_of(2'd0)) begin
            pick_ok = 1'b1; pick_code = 2'd0;
        end
        if (!hopper_empty_i[1] && remaining_q >= denom_of(2'd1)) begin
            pick_ok = 1'b1; pick_code = 2'd1;
        end
        if (!hopper_empty_i[3] && remaining_q >= denom_of(2'd3)) begin
            pick_ok = 1'b1; pick_code = 2'd3;
        end
        if (!hopper_empty_i[2] && remaining_q >= denom_of(2'd2)) begin
            pick_ok = 1'b1; pick_code = 2'd2;
        end
    end

    assign sense_hit    = hopper_sense_i[sel_q];
    assign remaining_d  = remaining_q - denom_of(sel_q);
    assign coin_count_d = (coin_count_q == 8'hFF) ? coin_count_q : coin_count_q + 8'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            coin_count_q <= '0;
            eject_q      <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            sensed_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        remaining_q  <= amount_i;
                        coin_count_q <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (remaining_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (pick_ok) begin
                        sel_q    <= pick_code;
                        eject_q  <= 4'b0001 << pick_code;
                        cnt_q    <= '0;
                        sensed_q <= 1'b0;
                        state_q  <= S_EJECT;
                    end else begin
                        error_q    <= 1'b1;
                        err_code_q <= 2'd1;
                        state_q    <= S_FAULT;
                    end
                end
                S_EJECT: begin
                    if (sense_hit) sensed_q <= 1'b1;
                    if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                        eject_q <= '0;
                        cnt_q   <= '0;
                        // A coin that dropped while the pulse was still on is paid right away.
                        if (sensed_q || sense_hit) begin
                            remaining_q  <= remaining_d;
                            coin_count_q <= coin_count_d;
                            state_q      <= S_SELECT;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (sense_hit) begin
                        remaining_q  <= remaining_d;
                        coin_count_q <= coin_count_d;
                        state_q      <= S_SELECT;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        error_q    <= 1'b1;
                        err_code_q <= 2'd2;
                        state_q    <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAULT: begin
                    if (fault_clr_i) begin
                        error_q    <= 1'b0;
                        err_code_q <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hopper_eject_o = eject_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign err_code_o     = err_code_q;
    assign remaining_o    = remaining_q;
    assign coin_count_o   = coin_count_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: the bench plays the hoppers and checks every transaction
// against a greedy change-making model computed from coin values.
module tb_change_dispenser_ctrl;
    localparam int CREDIT_W = 9;
    localparam int PULSE    = 4;
    localparam int TIMEOUT  = 255;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [CREDIT_W-1:0] amount;
    logic [3:0]          hopper_empty;
    logic [3:0]          hopper_sense;
    logic                fault_clr;
    logic [3:0]          hopper_eject;
    logic                busy;
    logic                done;
    logic                error;
    logic [1:0]          err_code;
    logic [CREDIT_W-1:0] remaining;
    logic [7:0]          coin_count;
    logic [2:0]          dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_q[$];
    int exp_err;
    int exp_rem_final;
    int exp_coins;

    change_dispenser_ctrl #(
        .CREDIT_W(CREDIT_W), .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .amount_i(amount),
        .hopper_empty_i(hopper_empty), .hopper_sense_i(hopper_sense), .fault_clr_i(fault_clr),
        .hopper_eject_o(hopper_eject), .busy_o(busy), .done_o(done), .error_o(error),
        .err_code_o(err_code), .remaining_o(remaining), .coin_count_o(coin_count),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int denom(input int code);
        case (code)
            0:       return 10;
            1:       return 20;
            3:       return 50;
            default: return 100;
        endcase
    endfunction

    // Greedy change-making over the non-empty hoppers, from the coin values directly.
    task automatic model(input int amt, input logic [3:0] empty, input bit no_sense);
        int rem;
        int best;
        int by_value[4] = '{2, 3, 1, 0};
        rem = amt;
        exp_q.delete();
        exp_err = 0;
        while (rem > 0) begin
            best = -1;
            foreach (by_value[k])
                if (best < 0 && !empty[by_value[k]] && denom(by_value[k]) <= rem) best = by_value[k];
            if (best < 0) begin
                exp_err = 1;
                break;
            end
            exp_q.push_back(best[1:0]);
            rem -= denom(best);
        end
        exp_rem_final = rem;
        exp_coins     = exp_q.size();
        if (no_sense && exp_q.size() > 0) begin
            exp_err       = 2;
            exp_rem_final = amt;
            exp_coins     = 0;
            while (exp_q.size() > 1) void'(exp_q.pop_back());
        end
    endtask

    // One transaction; called and returns at a falling edge.
    task automatic run_txn(input int amt, input logic [3:0] empty, input int delay,
                           input bit in_eject, input bit no_sense, input bit poke);
        int idx, run_rem, coins, pulse_len, wait_cnt, coin_idx;
        bit in_pulse, waiting, finished, first_seen;
        logic [1:0] cur, cur_exp;
        idx = 0; run_rem = amt; coins = 0; pulse_len = 0; wait_cnt = 0; coin_idx = 0;
        in_pulse = 0; waiting = 0; finished = 0; first_seen = 0; cur = 0; cur_exp = 0;
        model(amt, empty, no_sense);
        hopper_empty = empty;
        amount = amt[CREDIT_W-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 1;
        check("busy_after_start", busy, 1);
        check("no_eject_in_select", hopper_eject, 0);
        while (!finished && idx < 4000) begin
            @(negedge clk);
            idx++;
            hopper_sense = '0;
            start = 1'b0;
            if (!first_seen && (hopper_eject != 0 || done || error)) begin
                first_seen = 1;
                check("first_action_latency", idx, 2);
            end
            if (hopper_eject != 0) begin
                if (!in_pulse) begin
                    in_pulse = 1; pulse_len = 1; coin_idx = idx;
                    for (int b = 0; b < 4; b++) if (hopper_eject[b]) cur = b[1:0];
                    check("eject_onehot", $countones(hopper_eject), 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_eject", hopper_eject, 0);
                        cur_exp = cur;
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("eject_code", cur, cur_exp);
                    end
                    check("remaining_before_coin", remaining, run_rem);
                    check("count_before_coin", coin_count, coins);
                end else begin
                    pulse_len++;
                    if (pulse_len > PULSE) check("pulse_too_long", pulse_len, PULSE);
                end
                if (pulse_len == 2) begin
                    if (in_eject && !no_sense) hopper_sense[cur] = 1'b1;
                    if (poke) begin
                        start  = 1'b1;
                        amount = CREDIT_W'($urandom_range(0, 511));
                    end
                end
            end else if (in_pulse) begin
                in_pulse = 0;
                check("pulse_width", pulse_len, PULSE);
                if (!no_sense) begin
                    if (in_eject) begin
                        run_rem -= denom(cur_exp);
                        coins++;
                    end else begin
                        waiting = 1;
                        wait_cnt = 0;
                    end
                end
            end
            if (waiting) begin
                if (wait_cnt == delay) begin
                    hopper_sense[cur] = 1'b1;
                    waiting = 0;
                    run_rem -= denom(cur_exp);
                    coins++;
                end else if (wait_cnt == delay - 1) begin
                    hopper_sense = 4'b0001 << (cur + 2'd1);
                end
                wait_cnt++;
            end
            if (done) begin
                check("outcome_code", err_code, exp_err);
                check("done_remaining", remaining, exp_rem_final);
                check("done_coins", coin_count, exp_coins);
                check("done_busy", busy, 1);
                check("coins_left", exp_q.size(), 0);
                @(negedge clk);
                check("done_one_cycle", done, 0);
                check("busy_after_done", busy, 0);
                finished = 1;
            end else if (error) begin
                check("fault_code", err_code, exp_err);
                check("fault_remaining", remaining, exp_rem_final);
                check("fault_coins", coin_count, exp_coins);
                check("fault_eject_off", hopper_eject, 0);
                check("fault_busy", busy, 1);
                check("coins_left", exp_q.size(), 0);
                if (exp_err == 2) check("timeout_latency", idx - coin_idx, PULSE + TIMEOUT);
                start  = 1'b1;
                amount = CREDIT_W'($urandom_range(1, 511));
                @(negedge clk);
                start = 1'b0;
                check("fault_hold_error", error, 1);
                check("fault_hold_code", err_code, exp_err);
                check("fault_hold_remaining", remaining, exp_rem_final);
                fault_clr = 1'b1;
                @(negedge clk);
                fault_clr = 1'b0;
                check("clr_error", error, 0);
                check("clr_code", err_code, 0);
                check("clr_busy", busy, 0);
                finished = 1;
            end
        end
        if (!finished) check("txn_cycle_budget", 0, 1);
        hopper_sense = '0;
        start = 1'b0;
    endtask

    initial begin
        logic [3:0] empty;
        reset = 1'b1; start = 1'b0; amount = '0; hopper_empty = '0;
        hopper_sense = '0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_eject", hopper_eject, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_remaining", remaining, 0);
        check("reset_coin_count", coin_count, 0);
        reset = 1'b0;
        @(negedge clk);

        run_txn(180, 4'b0000, 3, 0, 0, 1);
        run_txn(60,  4'b1000, 2, 0, 0, 0);
        run_txn(40,  4'b0000, 0, 0, 1, 0);
        run_txn(25,  4'b0000, 1, 0, 0, 0);
        run_txn(0,   4'b0000, 0, 0, 0, 1);
        run_txn(70,  4'b0000, 0, 1, 0, 1);

        // Reset in the middle of an eject pulse.
        hopper_empty = '0; amount = CREDIT_W'(180); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_pre_eject", hopper_eject, 4'b0100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_eject", hopper_eject, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_remaining", remaining, 0);
        check("rst_mid_count", coin_count, 0);
        reset = 1'b0;
        @(negedge clk);
        run_txn(130, 4'b0000, 1, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            for (int b = 0; b < 4; b++) empty[b] = ($urandom_range(0, 3) == 0);
            run_txn($urandom_range(0, 40) * 10 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : 0),
                    empty, $urandom_range(0, 6), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
